serial_mod_n_checker: RTL and testbench

Parametrised serial divisibility checker: accepts a binary number one bit per qualified clock, tracks its remainder modulo a divisor loaded at run time, and flags divisibility after every accepted bit. Successor to the fixed divide-by-5 serial FSM: it adds a run-time divisor, MSB-first or LSB-first bit order, a bit-valid qualifier, explicit start/stop framing and a remainder output. It sits in the FSM library as the generic serial-arithmetic monitor.

---
 rtl/serial_mod_n_checker_pkg.sv | 26 ++
 rtl/serial_mod_n_checker_if.sv | 33 +++
 rtl/serial_mod_n_checker_mod_step.sv | 23 ++
 rtl/serial_mod_n_checker.sv | 120 ++++++++++++
 tb/tb_serial_mod_n_checker.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_mod_n_checker_pkg.sv
// serial_mod_pkg -- shared types and helpers for the serial modulo checker.
//   state_e  : controller states (S_IDLE, S_RUN)
//   mod_add  : (a + b) mod d for a, b < d, with one conditional subtract
package serial_mod_pkg;

  localparam int MOD_W = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Generic-width reference form of the modular add. Operands must already
  // be reduced below d, so the sum is below 2d and one subtract suffices.
  function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                               input logic [MOD_W-1:0] b,
                                               input logic [MOD_W-1:0] d);
    logic [MOD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, d}) begin
      sum = sum - {1'b0, d};
    end
    return sum[MOD_W-1:0];
  endfunction

endpackage

// File: rtl/serial_mod_n_checker_if.sv
// serial_mod_n_checker_if -- control/data bundle of the serial modulo checker.
//   start, div, lsb_first : framing and configuration (sampled on start)
//   bit_vld, i            : serial data bit and its qualifier
//   stop                  : ends the current number, results hold
//   y, rem, bit_cnt       : divisibility flag, remainder, accepted-bit count
//   busy, err             : running indicator, sticky illegal-divisor flag
// Modports: master drives the stimulus side, slave is the checker.
interface serial_mod_n_checker_if #(
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          start;
  logic [DW-1:0] div;
  logic          lsb_first;
  logic          bit_vld;
  logic          i;
  logic          stop;
  logic          y;
  logic [DW-1:0] rem;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          err;

  modport master (
    output start, div, lsb_first, bit_vld, i, stop,
    input  y, rem, bit_cnt, busy, err
  );

  modport slave (
    input  start, div, lsb_first, bit_vld, i, stop,
    output y, rem, bit_cnt, busy, err
  );
endinterface

// File: rtl/serial_mod_n_checker_mod_step.sv
// mod_step -- combinational modular adder: s = (a + b) mod d.
//   a, b : addends, each expected below d
//   d    : modulus
//   s    : reduced sum
module mod_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] s
);

  logic [DW:0] sum;
  logic        wrap;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign wrap = (sum >= {1'b0, d});
  // When wrapping, the true result is below d, so DW-bit modular
  // subtraction of the low bits yields it exactly.
  assign s    = wrap ? (sum[DW-1:0] - d) : sum[DW-1:0];

endmodule

// File: rtl/serial_mod_n_checker.sv
// serial_mod_n_checker -- serial divisibility monitor with run-time divisor.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : serial_mod_n_checker_if.slave (framing, data bit, results)
// Tracks value mod div of a bit stream (MSB- or LSB-first) and flags
// divisibility after every accepted bit.
module serial_mod_n_checker
  import serial_mod_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_mod_n_checker_if.slave  bus
);

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] p_q, p_d;      // weight of the next LSB-first bit, mod div
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d;
  logic          err_q, err_d;
  logic          lsb_q, lsb_d;

  logic [DW-1:0] rem_b;
  logic [DW-1:0] r_step;
  logic [DW-1:0] p_step;
  logic          div_legal;

  // MSB first: 2r+i = r + (r+i); r+i <= div-1+1 still fits DW bits.
  // LSB first: r + i*p.
  assign rem_b     = lsb_q ? (bus.i ? p_q : '0) : (r_q + DW'(bus.i));
  assign div_legal = (bus.div >= DW'(2));

  mod_step #(.DW(DW)) u_rem_step (
    .a (r_q),
    .b (rem_b),
    .d (div_q),
    .s (r_step)
  );

  mod_step #(.DW(DW)) u_wgt_step (
    .a (p_q),
    .b (p_q),
    .d (div_q),
    .s (p_step)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    err_d   = err_q;
    lsb_d   = lsb_q;

    if (bus.start) begin
      // A coinciding bit_vld is dropped; the empty number reads y=0.
      r_d   = '0;
      y_d   = 1'b0;
      cnt_d = '0;
      if (div_legal) begin
        div_d   = bus.div;
        lsb_d   = bus.lsb_first;
        p_d     = DW'(1);
        err_d   = 1'b0;
        state_d = S_RUN;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end else if (state_q == S_RUN) begin
      if (bus.stop) begin
        state_d = S_IDLE;
      end else if (bus.bit_vld) begin
        r_d = r_step;
        if (lsb_q) begin
          p_d = p_step;
        end
        y_d = (r_step == '0);
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      r_q     <= '0;
      p_q     <= DW'(1);
      cnt_q   <= '0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      err_q   <= err_d;
      lsb_q   <= lsb_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.rem     = r_q;
  assign bus.bit_cnt = cnt_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// tb_serial_mod_n_checker -- self-checking bench for serial_mod_n_checker.
// Table of per-cycle vectors with hand-derived expectations, then
// model-driven sequences (saturation, random bits, async reset).
module tb_serial_mod_n_checker;

  localparam int DW = 8;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_mod_n_checker_if #(.DW(DW), .CW(CW)) bus ();

  serial_mod_n_checker #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          st;
    logic [DW-1:0] dv;
    logic          lsb;
    logic          bv;
    logic          ib;
    logic          sp;
    logic          ey;
    logic [DW-1:0] erem;
    logic [CW-1:0] ecnt;
    logic          ebusy;
    logic          eerr;
  } vec_t;

  typedef struct {
    logic          y;
    logic [DW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: keeps the whole number and reduces it with %
  bit          m_run;
  int          m_d;
  longint unsigned m_val;
  int          m_k;
  bit          m_lsb;
  int          m_cnt;
  bit          m_y;
  bit          m_err;
  int          m_rem;

  function automatic vec_t mk(input int st, input int dv, input int lsb,
                              input int bv, input int ib, input int sp,
                              input int ey, input int erem, input int ecnt,
                              input int ebusy, input int eerr);
    vec_t v;
    v.st    = (st != 0);
    v.dv    = DW'(dv);
    v.lsb   = (lsb != 0);
    v.bv    = (bv != 0);
    v.ib    = (ib != 0);
    v.sp    = (sp != 0);
    v.ey    = (ey != 0);
    v.erem  = DW'(erem);
    v.ecnt  = CW'(ecnt);
    v.ebusy = (ebusy != 0);
    v.eerr  = (eerr != 0);
    return v;
  endfunction

  task automatic add(input int st, input int dv, input int lsb, input int bv,
                     input int ib, input int sp, input int ey, input int erem,
                     input int ecnt, input int ebusy, input int eerr);
    vecs.push_back(mk(st, dv, lsb, bv, ib, sp, ey, erem, ecnt, ebusy, eerr));
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.div       = '0;
    bus.lsb_first = 1'b0;
    bus.bit_vld   = 1'b0;
    bus.i         = 1'b0;
    bus.stop      = 1'b0;
  endtask

  // Drive one cycle, queue its expectation, pop and compare after the edge.
  task automatic apply(input string tag, input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    bus.start     = v.st;
    bus.div       = v.dv;
    bus.lsb_first = v.lsb;
    bus.bit_vld   = v.bv;
    bus.i         = v.ib;
    bus.stop      = v.sp;
    e.y    = v.ey;
    e.rem  = v.erem;
    e.cnt  = v.ecnt;
    e.busy = v.ebusy;
    e.err  = v.eerr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk({tag, ".y"},    idx, 32'(bus.y),       32'(g.y));
    chk({tag, ".rem"},  idx, 32'(bus.rem),     32'(g.rem));
    chk({tag, ".cnt"},  idx, 32'(bus.bit_cnt), 32'(g.cnt));
    chk({tag, ".busy"}, idx, 32'(bus.busy),    32'(g.busy));
    chk({tag, ".err"},  idx, 32'(bus.err),     32'(g.err));
    $display("%s #%0d st=%0b div=%0d bv=%0b i=%0b stop=%0b -> y=%0b rem=%0d cnt=%0d busy=%0b err=%0b",
             tag, idx, v.st, v.dv, v.bv, v.ib, v.sp,
             bus.y, bus.rem, bus.bit_cnt, bus.busy, bus.err);
  endtask

  task automatic model_reset();
    m_run = 0; m_d = 0; m_val = 0; m_k = 0; m_lsb = 0;
    m_cnt = 0; m_y = 0; m_err = 0; m_rem = 0;
  endtask

  // Advance the model by one cycle, then apply the cycle with its prediction.
  task automatic mstep(input string tag, input int idx, input int st,
                       input int dv, input int lsb, input int bv,
                       input int ib, input int sp);
    if (st != 0) begin
      m_val = 0; m_rem = 0; m_y = 0; m_cnt = 0;
      if (dv >= 2) begin
        m_d = dv; m_k = 0; m_lsb = (lsb != 0); m_err = 0; m_run = 1;
      end else begin
        m_err = 1; m_run = 0;
      end
    end else if (m_run) begin
      if (sp != 0) begin
        m_run = 0;
      end else if (bv != 0) begin
        if (m_lsb) begin
          if (ib != 0) m_val = m_val + (64'd1 << m_k);
        end else begin
          m_val = m_val * 2 + longint'(ib != 0);
        end
        m_k++;
        m_rem = int'(m_val % longint'(m_d));
        m_y   = (m_rem == 0);
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    apply(tag, idx, mk(st, dv, lsb, bv, ib, sp,
                       int'(m_y), m_rem, m_cnt, int'(m_run), int'(m_err)));
  endtask

  initial begin
    // st div lsb bv i stop | y rem cnt busy err
    // div=5 MSB first, 1,1,0,0,1 = 25
    add(1, 5, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 3, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0,  0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0,  0, 2, 4, 1, 0);
    add(0, 0, 0, 1, 1, 0,  1, 0, 5, 1, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 5, 0, 0);
    // div=3 LSB first, 0,1,1 = 6; the one-bit number 0 is divisible
    add(1, 3, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 2, 2, 1, 0);
    add(0, 0, 0, 1, 1, 0,  1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0);
    // illegal div=1, bits ignored in idle, then legal div=7
    add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1);
    add(1, 7, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    // restart with coinciding bit_vld: bit dropped, then 1,0,0,1 = 9
    add(1, 5, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,  0, 2, 2, 1, 0);
    add(1, 9, 0, 1, 1, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,  0, 2, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0,  0, 4, 3, 1, 0);
    add(0, 0, 0, 1, 1, 0,  1, 0, 4, 1, 0);
    add(0, 0, 0, 1, 1, 1,  1, 0, 4, 0, 0);   // stop beats bit_vld
    add(0, 0, 0, 0, 0, 0,  1, 0, 4, 0, 0);
    // div=0 illegal; div=2 smallest legal, start beats stop
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    add(1, 2, 0, 0, 0, 1,  0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0,  0, 1, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0,  0, 1, 2, 1, 0);   // gap holds
    add(0, 0, 0, 1, 0, 0,  1, 0, 3, 1, 0);
    // illegal start while running drops back to idle
    add(1, 1, 0, 1, 1, 0,  0, 0, 0, 0, 1);

    drive_idle();
    rst = 1'b0;
    #12;
    chk("reset.y",    0, 32'(bus.y),       32'd0);
    chk("reset.rem",  0, 32'(bus.rem),     32'd0);
    chk("reset.cnt",  0, 32'(bus.bit_cnt), 32'd0);
    chk("reset.busy", 0, 32'(bus.busy),    32'd0);
    chk("reset.err",  0, 32'(bus.err),     32'd0);
    #6;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < vecs.size(); n++) begin
      apply("tbl", n, vecs[n]);
    end

    // counter saturation, LSB first, bit_vld every other cycle
    model_reset();
    mstep("sat", 0, 1, 7, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      mstep("sat", k + 1, 0, 0, 0, int'(k % 2 == 0), int'($urandom_range(0, 1)), 0);
    end
    mstep("sat", 21, 0, 0, 0, 0, 0, 1);

    // random bits, largest divisor, MSB first
    mstep("rmsb", 0, 1, 255, 0, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      mstep("rmsb", k + 1, 0, 0, 0, int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 1)), 0);
    end
    mstep("rmsb", 31, 0, 0, 0, 1, 1, 1);

    // random bits, LSB first
    mstep("rlsb", 0, 1, 200, 1, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      mstep("rlsb", k + 1, 0, 0, 0, int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 1)), 0);
    end
    mstep("rlsb", 31, 0, 0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a number
    mstep("rst", 0, 1, 5, 0, 0, 0, 0);
    mstep("rst", 1, 0, 0, 0, 1, 1, 0);
    mstep("rst", 2, 0, 0, 0, 1, 1, 0);
    mstep("rst", 3, 0, 0, 0, 1, 1, 0);
    bus.bit_vld = 1'b1;
    bus.i       = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.y",    0, 32'(bus.y),       32'd0);
    chk("arst.rem",  0, 32'(bus.rem),     32'd0);
    chk("arst.cnt",  0, 32'(bus.bit_cnt), 32'd0);
    chk("arst.busy", 0, 32'(bus.busy),    32'd0);
    chk("arst.err",  0, 32'(bus.err),     32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    mstep("post", 0, 0, 0, 0, 1, 1, 0);
    mstep("post", 1, 0, 0, 0, 1, 1, 0);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
